apb_req_arbiter: RTL and testbench

- Round-robin scheduler that shares the single APB master bridge between NUM_REQ internal requesters.
- Accepts one transaction request per requester and serialises them onto the bridge's transfer/READ_WRITE/address/data inputs.
- Monitors APB completion (PENABLE, PREADY, PSLVERR) and returns read data and error status to the granted requester.
- Sits between the system-side requesters and the APB master bridge.

---
 rtl/apb_req_arbiter.sv | 166 ++++++++++++++++
 tb/tb_apb_req_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter sharing one APB master bridge between NUM_REQ requesters.
// Optional wait-state timeout is compiled in with `define APB_ARB_TIMEOUT_EN.
module apb_req_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic                      PCLK,
  input  logic                      PRESET,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_done,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic                      busy,
  output logic [2:0]                gnt_id,
  output logic                      transfer,
  output logic                      READ_WRITE,
  output logic [ADDR_W-1:0]         apb_write_paddr,
  output logic [ADDR_W-1:0]         apb_read_paddr,
  output logic [DATA_W-1:0]         apb_write_data,
  input  logic                      PENABLE,
  input  logic                      PREADY,
  input  logic                      PSLVERR,
  input  logic [DATA_W-1:0]         PRDATA
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t              r_state;
  logic [2:0]          r_last_grant;

`ifdef APB_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0]    r_wait_cnt;
`endif

  logic                w_any;
  logic [2:0]          w_winner;
  logic                w_sel_wr;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [DATA_W-1:0]   w_sel_wdata;
  logic [NUM_REQ-1:0]  w_done_vec;
  logic                w_complete;

  // Rotating-priority search starting one past the last granted requester.
  always_comb begin
    w_any    = 1'b0;
    w_winner = 3'd0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!w_any && req_valid[i] && (i == ((int'(r_last_grant) + k) % NUM_REQ))) begin
          w_any    = 1'b1;
          w_winner = 3'(i);
        end else begin
          w_any    = w_any;
        end
      end
    end
  end

  // Select the winner's request fields and build the completion one-hot.
  always_comb begin
    w_sel_wr    = 1'b0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    w_done_vec  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_winner == 3'(i)) begin
        w_sel_wr    = req_write[i];
        w_sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
        w_sel_wdata = req_wdata[i*DATA_W +: DATA_W];
      end else begin
        w_sel_wr    = w_sel_wr;
      end
      w_done_vec[i] = (gnt_id == 3'(i));
    end
  end

  // PSLVERR alone also ends the access: the bridge aborts on error.
  assign w_complete = PENABLE & (PREADY | PSLVERR);

  // Arbitration FSM with all outputs registered.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_state         <= S_IDLE;
      r_last_grant    <= 3'(NUM_REQ - 1);
      req_done        <= '0;
      rsp_rdata       <= '0;
      rsp_err         <= 1'b0;
      busy            <= 1'b0;
      gnt_id          <= 3'd0;
      transfer        <= 1'b0;
      READ_WRITE      <= 1'b0;
      apb_write_paddr <= '0;
      apb_read_paddr  <= '0;
      apb_write_data  <= '0;
`ifdef APB_ARB_TIMEOUT_EN
      r_wait_cnt      <= '0;
`endif
    end else begin
      transfer <= 1'b0;
      req_done <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            gnt_id          <= w_winner;
            READ_WRITE      <= w_sel_wr;
            apb_write_paddr <= w_sel_addr;
            apb_read_paddr  <= w_sel_addr;
            apb_write_data  <= w_sel_wr ? w_sel_wdata : '0;
            transfer        <= 1'b1;
            busy            <= 1'b1;
            r_state         <= S_ISSUE;
          end else begin
            r_state         <= S_IDLE;
          end
        end
        S_ISSUE: begin
`ifdef APB_ARB_TIMEOUT_EN
          r_wait_cnt <= '0;
`endif
          r_state    <= S_WAIT;
        end
        S_WAIT: begin
          if (w_complete) begin
            rsp_rdata <= (!READ_WRITE && !PSLVERR) ? PRDATA : '0;
            rsp_err   <= PSLVERR;
            req_done  <= w_done_vec;
            r_state   <= S_RESP;
`ifdef APB_ARB_TIMEOUT_EN
          end else if (r_wait_cnt == CNT_W'(TIMEOUT - 1)) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b1;
            req_done  <= w_done_vec;
            r_state   <= S_RESP;
          end else begin
            r_wait_cnt <= r_wait_cnt + CNT_W'(1);
            r_state    <= S_WAIT;
`else
          end else begin
            r_state   <= S_WAIT;
`endif
          end
        end
        S_RESP: begin
          r_last_grant <= gnt_id;
          busy         <= 1'b0;
          r_state      <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Directed self-checking bench for apb_req_arbiter with a scripted APB bridge/slave.
module tb_apb_req_arbiter;

  logic        PCLK = 1'b0;
  logic        PRESET = 1'b1;
  logic [3:0]  req_valid = 4'b0000;
  logic [3:0]  req_write = 4'b0000;
  logic [31:0] req_addr  = {8'h40, 8'h30, 8'h20, 8'h10};
  logic [31:0] req_wdata = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
  logic [3:0]  req_done;
  logic [7:0]  rsp_rdata;
  logic        rsp_err;
  logic        busy;
  logic [2:0]  gnt_id;
  logic        transfer;
  logic        READ_WRITE;
  logic [7:0]  apb_write_paddr;
  logic [7:0]  apb_read_paddr;
  logic [7:0]  apb_write_data;
  logic        PENABLE = 1'b0;
  logic        PREADY  = 1'b0;
  logic        PSLVERR = 1'b0;
  logic [7:0]  PRDATA  = 8'h00;

  int n_cmp = 0;
  int n_bad = 0;
  int lat_s;

  apb_req_arbiter dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_done(req_done), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy), .gnt_id(gnt_id),
    .transfer(transfer), .READ_WRITE(READ_WRITE), .apb_write_paddr(apb_write_paddr),
    .apb_read_paddr(apb_read_paddr), .apb_write_data(apb_write_data),
    .PENABLE(PENABLE), .PREADY(PREADY), .PSLVERR(PSLVERR), .PRDATA(PRDATA)
  );

  always #5 PCLK = ~PCLK;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check_val({tag, "_transfer"}, 32'(transfer), 32'd0);
    check_val({tag, "_busy"}, 32'(busy), 32'd0);
    check_val({tag, "_done"}, 32'(req_done), 32'd0);
    check_val({tag, "_gnt"}, 32'(gnt_id), 32'd0);
    check_val({tag, "_paddr"}, 32'(apb_read_paddr), 32'd0);
    check_val({tag, "_err"}, 32'(rsp_err), 32'd0);
  endtask

  // Waits (bounded) for transfer, plays bridge/slave, checks the whole transaction.
  task automatic serve(input string tag, input logic [2:0] exp_id, input int waits,
                       input logic err, input logic [7:0] prdata, input logic exp_wr,
                       input logic [7:0] exp_addr, input logic [7:0] exp_wdata,
                       input logic [7:0] exp_rdata, output int lat);
    int n = 0;
    @(negedge PCLK);
    while (!transfer && n < 20) begin
      @(negedge PCLK);
      n++;
    end
    lat = n;
    check_val({tag, "_transfer"}, 32'(transfer), 32'd1);
    check_val({tag, "_gnt"}, 32'(gnt_id), 32'(exp_id));
    check_val({tag, "_rw"}, 32'(READ_WRITE), 32'(exp_wr));
    check_val({tag, "_waddr"}, 32'(apb_write_paddr), 32'(exp_addr));
    check_val({tag, "_raddr"}, 32'(apb_read_paddr), 32'(exp_addr));
    check_val({tag, "_wdata"}, 32'(apb_write_data), 32'(exp_wdata));
    check_val({tag, "_busy"}, 32'(busy), 32'd1);
    @(negedge PCLK);
    check_val({tag, "_xfer_once"}, 32'(transfer), 32'd0);
    PENABLE = 1'b0;
    @(negedge PCLK);
    for (int w = 0; w <= waits; w++) begin
      PENABLE = 1'b1;
      if (w == waits) begin
        PREADY  = !err;
        PSLVERR = err;
        PRDATA  = prdata;
      end else begin
        PREADY  = 1'b0;
        PSLVERR = 1'b0;
        PRDATA  = 8'h77;
      end
      @(negedge PCLK);
      if (w < waits) begin
        check_val({tag, "_wait_xfer"}, 32'(transfer), 32'd0);
        check_val({tag, "_wait_done"}, 32'(req_done), 32'd0);
      end
    end
    check_val({tag, "_done"}, 32'(req_done), 32'(4'b0001 << exp_id));
    check_val({tag, "_rdata"}, 32'(rsp_rdata), 32'(exp_rdata));
    check_val({tag, "_rsp_err"}, 32'(rsp_err), 32'(err));
    PENABLE = 1'b0;
    PREADY  = 1'b0;
    PSLVERR = 1'b0;
    @(negedge PCLK);
    check_val({tag, "_done_1cyc"}, 32'(req_done), 32'd0);
    check_val({tag, "_busy_end"}, 32'(busy), 32'd0);
  endtask

  task automatic apply_reset();
    PRESET = 1'b1;
    @(negedge PCLK);
    check_idle_outputs("rst");
    @(negedge PCLK);
    PRESET = 1'b0;
  endtask

  initial begin
    @(negedge PCLK);
    check_idle_outputs("por");
    PRESET = 1'b0;

    // Single read from requester 0, zero-wait slave
    req_valid = 4'b0001;
    req_write = 4'b0000;
    serve("t1", 3'd0, 0, 1'b0, 8'hA5, 1'b0, 8'h10, 8'h00, 8'hA5, lat_s);
    check_val("t1_latency", 32'(lat_s), 32'd0);
    check_val("t1_hold", 32'(rsp_rdata), 32'hA5);
    req_valid = 4'b0000;

    // All requesters writing continuously: strict rotation from 0
    apply_reset();
    req_valid = 4'b1111;
    req_write = 4'b1111;
    serve("t2a", 3'd0, 0, 1'b0, 8'h00, 1'b1, 8'h10, 8'hA0, 8'h00, lat_s);
    serve("t2b", 3'd1, 0, 1'b0, 8'h00, 1'b1, 8'h20, 8'hB1, 8'h00, lat_s);
    serve("t2c", 3'd2, 0, 1'b0, 8'h00, 1'b1, 8'h30, 8'hC2, 8'h00, lat_s);
    serve("t2d", 3'd3, 0, 1'b0, 8'h00, 1'b1, 8'h40, 8'hD3, 8'h00, lat_s);
    serve("t2e", 3'd0, 0, 1'b0, 8'h00, 1'b1, 8'h10, 8'hA0, 8'h00, lat_s);

    // Write to 8'h20 with three wait states
    req_valid = 4'b0010;
    serve("t3", 3'd1, 3, 1'b0, 8'h00, 1'b1, 8'h20, 8'hB1, 8'h00, lat_s);

    // Error read (PSLVERR without PREADY), then the other pending requester
    req_valid = 4'b1010;
    req_write = 4'b0000;
    serve("t4err", 3'd3, 0, 1'b1, 8'hFF, 1'b0, 8'h40, 8'h00, 8'h00, lat_s);
    req_valid = 4'b0010;
    serve("t4next", 3'd1, 1, 1'b0, 8'h3C, 1'b0, 8'h20, 8'h00, 8'h3C, lat_s);

    // Asynchronous reset while in WAIT
    req_valid = 4'b1111;
    begin
      int n = 0;
      @(negedge PCLK);
      while (!transfer && n < 20) begin
        @(negedge PCLK);
        n++;
      end
    end
    check_val("t5_transfer", 32'(transfer), 32'd1);
    check_val("t5_gnt", 32'(gnt_id), 32'd2);
    @(negedge PCLK);
    @(negedge PCLK);
    PENABLE = 1'b1;
    #2 PRESET = 1'b1;
    #1 check_idle_outputs("t5_async");
    check_val("t5_rw", 32'(READ_WRITE), 32'd0);
    PENABLE = 1'b0;
    @(negedge PCLK);
    check_val("t5_no_done", 32'(req_done), 32'd0);
    @(negedge PCLK);
    PRESET = 1'b0;
    serve("t5after", 3'd0, 0, 1'b0, 8'h5A, 1'b0, 8'h10, 8'h00, 8'h5A, lat_s);

    // Slave never answers
    req_valid = 4'b1000;
    begin
      int n = 0;
      @(negedge PCLK);
      while (!transfer && n < 20) begin
        @(negedge PCLK);
        n++;
      end
    end
    check_val("t6_transfer", 32'(transfer), 32'd1);
    for (int k = 1; k <= 16; k++) begin
      @(negedge PCLK);
      check_val("t6_wait_done", 32'(req_done), 32'd0);
      PENABLE = 1'b1;
    end
    @(negedge PCLK);
`ifdef APB_ARB_TIMEOUT_EN
    check_val("t6_to_done", 32'(req_done), 32'b1000);
    check_val("t6_to_err", 32'(rsp_err), 32'd1);
    check_val("t6_to_rdata", 32'(rsp_rdata), 32'd0);
    req_valid = 4'b0000;
    PREADY = 1'b1;
    PRDATA = 8'hEE;
    @(negedge PCLK);
    check_val("t6_late_done", 32'(req_done), 32'd0);
    PENABLE = 1'b0;
    PREADY  = 1'b0;
    @(negedge PCLK);
    check_val("t6_late_idle", 32'(busy), 32'd0);
    check_val("t6_late_rdata", 32'(rsp_rdata), 32'd0);
`else
    check_val("t6_stuck_done", 32'(req_done), 32'd0);
    check_val("t6_stuck_busy", 32'(busy), 32'd1);
    repeat (8) @(negedge PCLK);
    check_val("t6_still_busy", 32'(busy), 32'd1);
    check_val("t6_still_xfer", 32'(transfer), 32'd0);
    check_val("t6_still_done", 32'(req_done), 32'd0);
    req_valid = 4'b0000;
    PENABLE   = 1'b0;
    apply_reset();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
